perf_lat_monitor: RTL and testbench

- Parametrised, multi-channel AXI transaction latency/throughput monitor for the perf-test kernel.
- Consumes per-channel request-accept and response-complete strobes with IDs, in the same form as the existing tt_* taps (arvalid&arready, rlast&rvalid&rready, and so on).
- Per channel, it tracks outstanding IDs and accumulates count, min, max and summed latency for the AXI-Lite register hub.
- Default NUM_CH=2: channel 0 is read, channel 1 is write.

---
 rtl/perf_mon_pkg.sv | 43 ++++
 rtl/perf_lat_chan.sv | 137 +++++++++++++
 rtl/perf_lat_monitor.sv | 156 +++++++++++++++
 tb/tb_perf_lat_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared types and helpers for the AXI latency monitor.
//   - mon_state_t : measurement FSM states
//   - DEF_*       : default widths / limits
//   - HIST_BINS   : latency histogram bin count (used when PERF_LAT_HIST_EN is defined)
//   - sat_add     : saturating add for counters up to 64 bits wide
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_ID_WIDTH  = 5;
  localparam int DEF_LAT_WIDTH = 32;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int DEF_SUM_WIDTH = 48;
  localparam int DEF_DRAIN_TMO = 4096;

  localparam int HIST_BINS  = 8;
  localparam int HIST_IDX_W = 3;

  // Saturating add of two values whose meaningful width is 'width' (<= 64).
  // Callers zero-extend their operands to 64 bits and truncate the result back.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [63:0] mask;
    logic [64:0] sum;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    sum  = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, mask}) return mask;
    return sum[63:0];
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] a,
                                          input int unsigned width);
    return sat_add(a, 64'd1, width);
  endfunction

endpackage

// File: rtl/perf_lat_chan.sv
// perf_lat_chan: one monitored channel -- open-ID table, error flags, statistics.
// Optional histogram built when PERF_LAT_HIST_EN is defined.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clear              start of a new measurement; wipes table, stats and errors
//   req_en, req_id     request accepted (already gated to RUN by the top)
//   rsp_en, rsp_id     response completed (already gated to RUN/DRAIN by the top)
//   ts                 free-running timestamp
//   txn_cnt, lat_min, lat_max, lat_sum, outstanding, err_dup, err_orphan  (registered)
//   lat_hist           HIST_BINS saturating counters (PERF_LAT_HIST_EN only)
module perf_lat_chan
  import perf_mon_pkg::*;
#(
  parameter int ID_WIDTH  = DEF_ID_WIDTH,
  parameter int LAT_WIDTH = DEF_LAT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH
`ifdef PERF_LAT_HIST_EN
  , parameter int HIST_SHIFT = 4
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 req_en,
  input  logic [ID_WIDTH-1:0]  req_id,
  input  logic                 rsp_en,
  input  logic [ID_WIDTH-1:0]  rsp_id,
  input  logic [LAT_WIDTH-1:0] ts,
  output logic [CNT_WIDTH-1:0] txn_cnt,
  output logic [LAT_WIDTH-1:0] lat_min,
  output logic [LAT_WIDTH-1:0] lat_max,
  output logic [SUM_WIDTH-1:0] lat_sum,
  output logic [ID_WIDTH:0]    outstanding,
  output logic                 err_dup,
  output logic                 err_orphan
`ifdef PERF_LAT_HIST_EN
  , output logic [HIST_BINS*CNT_WIDTH-1:0] lat_hist
`endif
);

  localparam int DEPTH = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] OUT_ONE = (ID_WIDTH + 1)'(1);

  logic [DEPTH-1:0]     valid_reg, valid_next;
  logic [LAT_WIDTH-1:0] stamp_mem [DEPTH];

  logic [CNT_WIDTH-1:0] txn_cnt_reg;
  logic [LAT_WIDTH-1:0] lat_min_reg, lat_max_reg;
  logic [SUM_WIDTH-1:0] lat_sum_reg;
  logic [ID_WIDTH:0]    outstanding_reg, outstanding_next;
  logic                 err_dup_reg, err_orphan_reg;

  logic                 rsp_hit, rsp_orphan, req_dup, req_new;
  logic [LAT_WIDTH-1:0] lat;

  // Response is resolved against the table state before this cycle's request,
  // so a close and reopen of the same ID in one cycle is not a duplicate.
  assign rsp_hit    = rsp_en &&  valid_reg[rsp_id];
  assign rsp_orphan = rsp_en && !valid_reg[rsp_id];
  assign req_dup    = req_en && valid_reg[req_id] && !(rsp_hit && (rsp_id == req_id));
  assign req_new    = req_en && !req_dup;
  // Modular subtraction: latencies >= 2**LAT_WIDTH alias silently.
  assign lat        = ts - stamp_mem[rsp_id];

  always_comb begin
    valid_next = valid_reg;
    if (rsp_hit) valid_next[rsp_id] = 1'b0;
    if (req_en)  valid_next[req_id] = 1'b1;
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_new && !rsp_hit)      outstanding_next = outstanding_reg + OUT_ONE;
    else if (!req_new && rsp_hit) outstanding_next = outstanding_reg - OUT_ONE;
  end

  // Stamps need no reset: an entry is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (req_en && !clear) stamp_mem[req_id] <= ts;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_reg       <= '0;
      outstanding_reg <= '0;
      txn_cnt_reg     <= '0;
      lat_min_reg     <= '1;
      lat_max_reg     <= '0;
      lat_sum_reg     <= '0;
      err_dup_reg     <= 1'b0;
      err_orphan_reg  <= 1'b0;
    end else begin
      valid_reg       <= valid_next;
      outstanding_reg <= outstanding_next;
      if (rsp_hit) begin
        txn_cnt_reg <= CNT_WIDTH'(sat_inc(64'(txn_cnt_reg), CNT_WIDTH));
        lat_sum_reg <= SUM_WIDTH'(sat_add(64'(lat_sum_reg), 64'(lat), SUM_WIDTH));
        if (lat < lat_min_reg) lat_min_reg <= lat;
        if (lat > lat_max_reg) lat_max_reg <= lat;
      end
      if (rsp_orphan) err_orphan_reg <= 1'b1;
      if (req_dup)    err_dup_reg    <= 1'b1;
    end
  end

  assign txn_cnt     = txn_cnt_reg;
  assign lat_min     = lat_min_reg;
  assign lat_max     = lat_max_reg;
  assign lat_sum     = lat_sum_reg;
  assign outstanding = outstanding_reg;
  assign err_dup     = err_dup_reg;
  assign err_orphan  = err_orphan_reg;

`ifdef PERF_LAT_HIST_EN
  logic [LAT_WIDTH-1:0]  lat_shr;
  logic [HIST_IDX_W-1:0] hist_bin;

  // Everything at or above the last bin boundary lands in the top bin.
  assign lat_shr  = lat >> HIST_SHIFT;
  assign hist_bin = (lat_shr > LAT_WIDTH'(HIST_BINS - 1)) ? HIST_IDX_W'(HIST_BINS - 1)
                                                          : lat_shr[HIST_IDX_W-1:0];

  genvar gi;
  for (gi = 0; gi < HIST_BINS; gi++) begin : g_bin
    logic [CNT_WIDTH-1:0] bin_reg;
    always_ff @(posedge clk) begin
      if (reset || clear)
        bin_reg <= '0;
      else if (rsp_hit && (hist_bin == HIST_IDX_W'(gi)))
        bin_reg <= CNT_WIDTH'(sat_inc(64'(bin_reg), CNT_WIDTH));
    end
    assign lat_hist[gi*CNT_WIDTH +: CNT_WIDTH] = bin_reg;
  end
`endif

endmodule

// File: rtl/perf_lat_monitor.sv
// perf_lat_monitor: multi-channel AXI latency/throughput monitor.
// Build option: define PERF_LAT_HIST_EN to add the lat_hist port and the
// HIST_SHIFT parameter (per-channel 8-bin latency histogram).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start_pulse, stop_pulse  measurement control (start wins over stop)
//   req_fire/req_id          per-channel request accept strobes and IDs
//   rsp_fire/rsp_id          per-channel response complete strobes and IDs
//   busy, done_pulse, drain_tmo, run_cycles   measurement status
//   txn_cnt, lat_min, lat_max, lat_sum, outstanding, err_dup, err_orphan
//                            per-channel statistics, channel c at slice c
module perf_lat_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int ID_WIDTH  = DEF_ID_WIDTH,
  parameter int LAT_WIDTH = DEF_LAT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH,
  parameter int DRAIN_TMO = DEF_DRAIN_TMO
`ifdef PERF_LAT_HIST_EN
  , parameter int HIST_SHIFT = 4
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_pulse,
  input  logic                          stop_pulse,
  input  logic [NUM_CH-1:0]             req_fire,
  input  logic [NUM_CH*ID_WIDTH-1:0]    req_id,
  input  logic [NUM_CH-1:0]             rsp_fire,
  input  logic [NUM_CH*ID_WIDTH-1:0]    rsp_id,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          drain_tmo,
  output logic [LAT_WIDTH-1:0]          run_cycles,
  output logic [NUM_CH*CNT_WIDTH-1:0]   txn_cnt,
  output logic [NUM_CH*LAT_WIDTH-1:0]   lat_min,
  output logic [NUM_CH*LAT_WIDTH-1:0]   lat_max,
  output logic [NUM_CH*SUM_WIDTH-1:0]   lat_sum,
  output logic [NUM_CH*(ID_WIDTH+1)-1:0] outstanding,
  output logic [NUM_CH-1:0]             err_dup,
  output logic [NUM_CH-1:0]             err_orphan
`ifdef PERF_LAT_HIST_EN
  , output logic [NUM_CH*HIST_BINS*CNT_WIDTH-1:0] lat_hist
`endif
);

  localparam int DRAIN_W = $clog2(DRAIN_TMO + 1);

  mon_state_t           state_reg, state_next;
  logic [LAT_WIDTH-1:0] ts_reg;
  logic [LAT_WIDTH-1:0] run_cycles_reg;
  logic [DRAIN_W-1:0]   drain_cnt_reg;
  logic                 busy_reg, done_pulse_reg, drain_tmo_reg;
  logic                 tmo_exit;
  logic                 in_run, in_resp;
  logic [NUM_CH-1:0]    ch_idle;

  // A start in the same cycle as traffic clears the channel instead of counting it.
  assign in_run  = (state_reg == RUN) && !start_pulse;
  assign in_resp = ((state_reg == RUN) || (state_reg == DRAIN)) && !start_pulse;

  always_comb begin
    state_next = state_reg;
    tmo_exit   = 1'b0;
    if (start_pulse) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        IDLE:  state_next = IDLE;
        RUN:   if (stop_pulse) state_next = DRAIN;
        DRAIN: begin
          if (&ch_idle) begin
            state_next = DONE;
          end else if (drain_cnt_reg == DRAIN_W'(DRAIN_TMO - 1)) begin
            state_next = DONE;
            tmo_exit   = 1'b1;
          end
        end
        DONE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ts_reg         <= '0;
      run_cycles_reg <= '0;
      drain_cnt_reg  <= '0;
      busy_reg       <= 1'b0;
      done_pulse_reg <= 1'b0;
      drain_tmo_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ts_reg         <= ts_reg + LAT_WIDTH'(1);
      busy_reg       <= (state_next == RUN) || (state_next == DRAIN);
      done_pulse_reg <= (state_next == DONE) && (state_reg != DONE);

      if (start_pulse)   drain_tmo_reg <= 1'b0;
      else if (tmo_exit) drain_tmo_reg <= 1'b1;

      if (start_pulse)
        run_cycles_reg <= '0;
      else if ((state_reg == RUN) || (state_reg == DRAIN))
        run_cycles_reg <= LAT_WIDTH'(sat_inc(64'(run_cycles_reg), LAT_WIDTH));

      // Counts cycles already spent in DRAIN; zero on every entry.
      if ((state_reg == DRAIN) && (state_next == DRAIN))
        drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
      else
        drain_cnt_reg <= '0;
    end
  end

  assign busy       = busy_reg;
  assign done_pulse = done_pulse_reg;
  assign drain_tmo  = drain_tmo_reg;
  assign run_cycles = run_cycles_reg;

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    perf_lat_chan #(
      .ID_WIDTH  (ID_WIDTH),
      .LAT_WIDTH (LAT_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .SUM_WIDTH (SUM_WIDTH)
`ifdef PERF_LAT_HIST_EN
      , .HIST_SHIFT(HIST_SHIFT)
`endif
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .clear       (start_pulse),
      .req_en      (req_fire[gi] && in_run),
      .req_id      (req_id[gi*ID_WIDTH +: ID_WIDTH]),
      .rsp_en      (rsp_fire[gi] && in_resp),
      .rsp_id      (rsp_id[gi*ID_WIDTH +: ID_WIDTH]),
      .ts          (ts_reg),
      .txn_cnt     (txn_cnt[gi*CNT_WIDTH +: CNT_WIDTH]),
      .lat_min     (lat_min[gi*LAT_WIDTH +: LAT_WIDTH]),
      .lat_max     (lat_max[gi*LAT_WIDTH +: LAT_WIDTH]),
      .lat_sum     (lat_sum[gi*SUM_WIDTH +: SUM_WIDTH]),
      .outstanding (outstanding[gi*(ID_WIDTH+1) +: ID_WIDTH+1]),
      .err_dup     (err_dup[gi]),
      .err_orphan  (err_orphan[gi])
`ifdef PERF_LAT_HIST_EN
      , .lat_hist  (lat_hist[gi*HIST_BINS*CNT_WIDTH +: HIST_BINS*CNT_WIDTH])
`endif
    );
    assign ch_idle[gi] = (outstanding[gi*(ID_WIDTH+1) +: ID_WIDTH+1] == '0);
  end

endmodule

// File: tb/tb_perf_lat_monitor.sv
// Directed bench for perf_lat_monitor (NUM_CH=2, ID_WIDTH=5, DRAIN_TMO=16).
module tb_perf_lat_monitor;

  localparam int NC  = 2;
  localparam int IW  = 5;
  localparam int LW  = 32;
  localparam int CW  = 32;
  localparam int SW  = 48;
  localparam int TMO = 16;
  localparam logic [63:0] ONES32 = 64'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_pulse, stop_pulse;
  logic [NC-1:0]      req_fire, rsp_fire;
  logic [NC*IW-1:0]   req_id, rsp_id;
  logic               busy, done_pulse, drain_tmo;
  logic [LW-1:0]      run_cycles;
  logic [NC*CW-1:0]   txn_cnt;
  logic [NC*LW-1:0]   lat_min, lat_max;
  logic [NC*SW-1:0]   lat_sum;
  logic [NC*(IW+1)-1:0] outstanding;
  logic [NC-1:0]      err_dup, err_orphan;
`ifdef PERF_LAT_HIST_EN
  logic [NC*8*CW-1:0] lat_hist;
`endif

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  perf_lat_monitor #(
    .NUM_CH(NC), .ID_WIDTH(IW), .LAT_WIDTH(LW), .CNT_WIDTH(CW),
    .SUM_WIDTH(SW), .DRAIN_TMO(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .req_fire(req_fire), .req_id(req_id), .rsp_fire(rsp_fire), .rsp_id(rsp_id),
    .busy(busy), .done_pulse(done_pulse), .drain_tmo(drain_tmo), .run_cycles(run_cycles),
    .txn_cnt(txn_cnt), .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
    .outstanding(outstanding), .err_dup(err_dup), .err_orphan(err_orphan)
`ifdef PERF_LAT_HIST_EN
    , .lat_hist(lat_hist)
`endif
  );

  function automatic logic [63:0] tc(input int c);  return 64'(txn_cnt[c*CW +: CW]);          endfunction
  function automatic logic [63:0] mn(input int c);  return 64'(lat_min[c*LW +: LW]);          endfunction
  function automatic logic [63:0] mx(input int c);  return 64'(lat_max[c*LW +: LW]);          endfunction
  function automatic logic [63:0] sm(input int c);  return 64'(lat_sum[c*SW +: SW]);          endfunction
  function automatic logic [63:0] os(input int c);  return 64'(outstanding[c*(IW+1) +: IW+1]); endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    req_fire = '0;
    rsp_fire = '0;
  endtask

  task automatic set_req(input int c, input int id);
    req_fire[c] = 1'b1;
    req_id[c*IW +: IW] = IW'(id);
  endtask

  task automatic set_rsp(input int c, input int id);
    rsp_fire[c] = 1'b1;
    rsp_id[c*IW +: IW] = IW'(id);
  endtask

  task automatic one_req(input int c, input int id);
    set_req(c, id); tick(); clr_in();
  endtask

  task automatic one_rsp(input int c, input int id);
    set_rsp(c, id); tick(); clr_in();
  endtask

  // Request, then the response exactly 'lat' clock edges later.
  task automatic txn(input int c, input int id, input int lat);
    one_req(c, id);
    repeat (lat - 1) tick();
    one_rsp(c, id);
    $display("txn ch%0d id%0d lat=%0d", c, id, lat);
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cnt);
    cnt = 0;
    while (done_pulse !== 1'b1 && cnt < max_cyc) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_pulse = 1'b0; stop_pulse = 1'b0;
    req_fire = '0; rsp_fire = '0; req_id = '0; rsp_id = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy",    64'(busy), 64'd0);
    chk("rst_done",    64'(done_pulse), 64'd0);
    chk("rst_tmo",     64'(drain_tmo), 64'd0);
    chk("rst_txn0",    tc(0), 64'd0);
    chk("rst_min1",    mn(1), ONES32);
    chk("rst_max0",    mx(0), 64'd0);
    chk("rst_out0",    os(0), 64'd0);
    chk("rst_errs",    64'({err_dup, err_orphan}), 64'd0);

    // Single read transaction, latency 15
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    txn(0, 3, 15);
    chk("t1_txn0", tc(0), 64'd1);
    chk("t1_min0", mn(0), 64'd15);
    chk("t1_max0", mx(0), 64'd15);
    chk("t1_sum0", sm(0), 64'd15);
    chk("t1_out0", os(0), 64'd0);
    pulse_stop();
    chk("t1_drain_busy", 64'(busy), 64'd1);
    wait_done(10, n);
    chk("t1_done_delay", 64'(n), 64'd1);
    chk("t1_done", 64'(done_pulse), 64'd1);
    chk("t1_tmo", 64'(drain_tmo), 64'd0);
    chk("t1_run_cycles", 64'(run_cycles), 64'd18);
    tick();
    chk("t1_done_low", 64'(done_pulse), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Out-of-order completions on channel 1: latencies 3, 6, 8
    pulse_start();
    one_req(1, 0);
    one_req(1, 1);
    one_req(1, 2);
    chk("t2_out1_open", os(1), 64'd3);
    tick(); tick();
    one_rsp(1, 2);
    one_rsp(1, 0);
    tick(); tick();
    one_rsp(1, 1);
    $display("txn ch1 ooo ids 2,0,1 lat=3,6,8");
    chk("t2_txn1", tc(1), 64'd3);
    chk("t2_min1", mn(1), 64'd3);
    chk("t2_max1", mx(1), 64'd8);
    chk("t2_sum1", sm(1), 64'd17);
    chk("t2_out1", os(1), 64'd0);
    chk("t2_txn0_cleared", tc(0), 64'd0);
    chk("t2_min0_cleared", mn(0), ONES32);

    // Same-cycle close/reopen of id 7 on channel 0
    one_req(0, 7);
    chk("t3_out0_open", os(0), 64'd1);
    repeat (3) tick();
    set_rsp(0, 7); set_req(0, 7); tick(); clr_in();
    $display("txn ch0 id7 close+reopen lat=4");
    chk("t3_txn0", tc(0), 64'd1);
    chk("t3_sum0", sm(0), 64'd4);
    chk("t3_out0", os(0), 64'd1);
    chk("t3_dup_none", 64'(err_dup), 64'd0);
    chk("t3_orph_none", 64'(err_orphan), 64'd0);
    one_rsp(0, 9);
    $display("txn ch0 orphan rsp id9");
    chk("t3_orphan", 64'(err_orphan), 64'd1);
    chk("t3_orphan_nodup", 64'(err_dup), 64'd0);
    chk("t3_orphan_txn0", tc(0), 64'd1);
    one_req(0, 7);
    $display("txn ch0 dup req id7");
    chk("t3_dup", 64'(err_dup), 64'd1);
    chk("t3_dup_out0", os(0), 64'd1);

    // Drain timeout with id 7 still open
    pulse_stop();
    wait_done(40, n);
    chk("t4_drain_cycles", 64'(n), 64'd16);
    chk("t4_tmo", 64'(drain_tmo), 64'd1);
    chk("t4_out0", os(0), 64'd1);
    tick();

    // Reset mid-RUN with 4 outstanding
    pulse_start();
    chk("t5_start_clr_tmo", 64'(drain_tmo), 64'd0);
    chk("t5_start_clr_out", os(0), 64'd0);
    for (int i = 1; i <= 4; i++) one_req(0, i);
    chk("t5_out0_4", os(0), 64'd4);
    reset = 1'b1;
    tick();
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_out0", os(0), 64'd0);
    chk("t5_rst_tmo", 64'(drain_tmo), 64'd0);
    chk("t5_rst_run", 64'(run_cycles), 64'd0);
    chk("t5_rst_txn1", tc(1), 64'd0);
    chk("t5_rst_min1", mn(1), ONES32);
    chk("t5_rst_sum1", sm(1), 64'd0);
    chk("t5_rst_errs", 64'({err_dup, err_orphan}), 64'd0);
    reset = 1'b0;
    tick();

    // Traffic in IDLE is ignored
    set_req(1, 4); set_rsp(1, 4); tick(); clr_in();
    chk("t5_idle_out1", os(1), 64'd0);
    chk("t5_idle_orph", 64'(err_orphan), 64'd0);

    // start_pulse during DONE clears statistics
    pulse_start();
    txn(0, 5, 2);
    chk("t5_min0", mn(0), 64'd2);
    pulse_stop();
    wait_done(10, n);
    chk("t5_in_done", 64'(done_pulse), 64'd1);
    pulse_start();
    chk("t5_restart_min0", mn(0), ONES32);
    chk("t5_restart_txn0", tc(0), 64'd0);
    chk("t5_restart_busy", 64'(busy), 64'd1);
    chk("t5_restart_run", 64'(run_cycles), 64'd0);

`ifdef PERF_LAT_HIST_EN
    // Histogram, HIST_SHIFT=4: bins 0, 1, 7
    txn(0, 1, 3);
    txn(0, 2, 20);
    txn(0, 3, 500);
    chk("t6_bin0", 64'(lat_hist[0*CW +: CW]), 64'd1);
    chk("t6_bin1", 64'(lat_hist[1*CW +: CW]), 64'd1);
    chk("t6_bin2", 64'(lat_hist[2*CW +: CW]), 64'd0);
    chk("t6_bin7", 64'(lat_hist[7*CW +: CW]), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
